diff_multi: RTL and testbench
=============================

Name: diff_multi

Overview:
- Multi-channel change detector; parametrised successor of the single-channel diff block.
- Compares CHANNELS independent DATA_WIDTH-wide inputs against their last sampled values.
- Raises per-channel change pulses, queues unmasked changes as sticky pending events, and reports them one at a time over a valid/ready event port with round-robin arbitration.
- Sits between status/register sources and the control core's event/interrupt logic.

Parameters:
- DATA_WIDTH, 8, width of each channel's data.
- CHANNELS, 4, number of monitored channels (>=2).
- CHAN_W, $clog2(CHANNELS), width of the channel index.
- STABLE_COUNT, 3, consecutive identical enabled samples needed to accept a change (used only with DIFF_DEBOUNCE_EN; >=1).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  sample enable; no sampling when low.
- i_data  input  CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- i_mask  input  CHANNELS  1 = channel c excluded from pending/event reporting.
- i_ready  input  1  event consumer accepts the current event.
- i_clr_ovf  input  1  clears o_overflow.
- o_changed  output  CHANNELS  per-channel one-cycle change pulse, registered.
- o_valid  output  1  event slot holds an event.
- o_chan  output  CHAN_W  index of the reported channel.
- o_value  output  DATA_WIDTH  value of that channel when the change was accepted.
- o_overflow  output  1  sticky: a change was lost.

Behaviour:
- Single clock i_clk. Reset i_rst is asynchronous, active-high. Reset clears all reference registers, snapshots, pending bits, the round-robin pointer, o_changed, o_valid, o_chan, o_value and o_overflow to 0.
- Detection, per edge with i_en=1, for each channel c:
  - A change is accepted when data_c != ref[c]. On accept: ref[c] <= data_c and o_changed[c] <= 1 (regardless of mask).
  - Otherwise o_changed[c] <= 0.
- With i_en=0: o_changed <= 0; ref is unchanged; the event port keeps operating.
- Because ref resets to 0, the first enabled sample of a nonzero value is a change.
- Pending:
  - An accepted change on an unmasked channel sets pending[c] and snap[c] <= data_c.
  - If pending[c] was already set and is not being drained this cycle, snap[c] is overwritten with the newest value and o_overflow <= 1.
  - Masked channels never set pending. Raising a mask bit does not clear an existing pending bit.
- Event slot:
  - The slot loads when empty, or when o_valid && i_ready (back-to-back, no bubble).
  - Selection: first pending channel at or after ptr, scanning upward and wrapping modulo CHANNELS.
  - On load: o_valid <= 1, o_chan <= selected index, o_value <= snap[sel] as held before the edge, pending[sel] cleared, ptr <= sel+1 (wraps to 0).
  - If no channel is pending and the slot is being emptied: o_valid <= 0.
- Latency: change sampled at edge N → o_changed and pending high after edge N → earliest o_valid after edge N+1.
- Handshake: while o_valid && !i_ready, o_chan and o_value hold stable. Transfer occurs on an edge with o_valid && i_ready.
- Simultaneous events:
  - A new change on the channel being loaded in the same cycle: the set wins. pending stays 1, snap takes the new value, no overflow.
  - o_overflow: a new overflow in the same cycle as i_clr_ovf wins, so o_overflow stays 1.
- Mid-operation reset: everything is cleared immediately, asynchronously, including any in-flight event.

Optional Feature:
- Macro: DIFF_DEBOUNCE_EN.
- Defined:
  - Per channel, a candidate register and a counter of width $clog2(STABLE_COUNT+1).
  - An enabled sample that differs from ref[c] and equals the candidate increments the counter.
  - A differing sample that differs from the candidate reloads the candidate and sets the count to 1.
  - A sample equal to ref[c] clears the count.
  - A change is accepted only when the count reaches STABLE_COUNT; the count then clears.
  - Disabled samples neither advance nor clear the counter.
- Undefined: no candidate registers or counters; a change is accepted on the first differing sample.

Test Plan:
- Bench configuration: CHANNELS=4, DATA_WIDTH=8.
- Reset, i_en=1, ch2 data 0x00→0xA5 at edge 5, i_ready=1 → o_changed=4'b0100 for one cycle after edge 5; o_valid=1, o_chan=2, o_value=0xA5 after edge 6; o_valid=0 after edge 7.
- ch0, ch1 and ch3 change in the same cycle, ptr=0, i_ready=1 → events are ch0, ch1, ch3 on consecutive cycles; ptr ends at 0.
- i_ready=0 and ch1 changes 0x10→0x20→0x30 on successive edges → ch1 event holds 0x10 stable; o_overflow=1 after the third change; after i_ready=1, the next ch1 event carries 0x30; i_clr_ovf clears o_overflow.
- i_mask=4'b0001, ch0 changes → o_changed[0] pulses, o_valid stays 0; ch0 equal to the new value afterwards produces no pulse.
- i_en=0 while ch3 changes to 0x7F, then i_en=1 → no pulse while disabled; pulse and event on the first enabled edge. Assert i_rst mid-handshake → o_valid drops immediately and no events resume.
- DIFF_DEBOUNCE_EN with STABLE_COUNT=3:
  - ch0 sequence 0x00,0x11,0x22,0x22,0x22 → change accepted on the third 0x22 only, o_value=0x22.
  - ch0 glitch 0x11 then back to 0x00 → no event.

Source files
------------

// File: rtl/diff_multi.sv
// Multi-channel change detector with sticky pending events and a round-robin valid/ready event port.
// Optional input debounce per channel is enabled with `define DIFF_DEBOUNCE_EN.
module diff_multi #(
   parameter int DATA_WIDTH   = 8,
   parameter int CHANNELS     = 4,
   parameter int CHAN_W       = $clog2(CHANNELS),
   parameter int STABLE_COUNT = 3
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_en,
   input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
   input  logic [CHANNELS-1:0]            i_mask,
   input  logic                           i_ready,
   input  logic                           i_clr_ovf,
   output logic [CHANNELS-1:0]            o_changed,
   output logic                           o_valid,
   output logic [CHAN_W-1:0]              o_chan,
   output logic [DATA_WIDTH-1:0]          o_value,
   output logic                           o_overflow
);

   logic [CHANNELS-1:0][DATA_WIDTH-1:0] data_w;
   logic [CHANNELS-1:0][DATA_WIDTH-1:0] ref_q, ref_d, snap_q, snap_d;
   logic [CHANNELS-1:0]                 accept, set_p, drain;
   logic [CHANNELS-1:0]                 pending_q, pending_d, changed_q;
   logic [CHAN_W-1:0]                   ptr_q, ptr_d, chan_q, chan_d, sel;
   logic [DATA_WIDTH-1:0]               value_q, value_d;
   logic                                valid_q, valid_d, ovf_q, ovf_d;
   logic                                found, load;
   int                                  idx;

   assign data_w = i_data;

`ifdef DIFF_DEBOUNCE_EN
   localparam int CNT_W = $clog2(STABLE_COUNT + 1);
   logic [CHANNELS-1:0][DATA_WIDTH-1:0] cand_q, cand_d;
   logic [CHANNELS-1:0][CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]                    nxt;

   // A differing value must be seen STABLE_COUNT times in a row before it is accepted.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      accept = '0;
      nxt    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (i_en) begin
            if (data_w[c] == ref_q[c]) begin
               cnt_d[c] = '0;
            end else begin
               nxt       = (data_w[c] == cand_q[c]) ? cnt_q[c] + CNT_W'(1) : CNT_W'(1);
               cand_d[c] = data_w[c];
               if (nxt == CNT_W'(STABLE_COUNT)) begin
                  accept[c] = 1'b1;
                  cnt_d[c]  = '0;
               end else begin
                  cnt_d[c] = nxt;
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cand_q <= '0;
         cnt_q  <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end
`else
   always_comb begin
      accept = '0;
      for (int c = 0; c < CHANNELS; c++)
         accept[c] = i_en && (data_w[c] != ref_q[c]);
   end
`endif

   // Round-robin pick: first pending channel at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = (int'(ptr_q) + i) % CHANNELS;
         if (!found && pending_q[idx]) begin
            found = 1'b1;
            sel   = CHAN_W'(idx);
         end
      end
   end

   always_comb begin
      ref_d   = ref_q;
      snap_d  = snap_q;
      set_p   = accept & ~i_mask;
      load    = !valid_q || i_ready;
      drain   = '0;
      valid_d = valid_q;
      chan_d  = chan_q;
      value_d = value_q;
      ptr_d   = ptr_q;
      for (int c = 0; c < CHANNELS; c++) begin
         if (accept[c]) ref_d[c]  = data_w[c];
         if (set_p[c])  snap_d[c] = data_w[c];
      end
      if (load) begin
         if (found) begin
            drain[sel] = 1'b1;
            valid_d    = 1'b1;
            chan_d     = sel;
            value_d    = snap_q[sel];
            ptr_d      = (sel == CHAN_W'(CHANNELS - 1)) ? '0 : sel + CHAN_W'(1);
         end else begin
            valid_d = 1'b0;
         end
      end
      // A fresh set on the channel being drained wins and is not a loss.
      pending_d = set_p | (pending_q & ~drain);
      ovf_d     = (|(set_p & pending_q & ~drain)) | (ovf_q & ~i_clr_ovf);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ref_q     <= '0;
         snap_q    <= '0;
         pending_q <= '0;
         changed_q <= '0;
         ptr_q     <= '0;
         valid_q   <= 1'b0;
         chan_q    <= '0;
         value_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         ref_q     <= ref_d;
         snap_q    <= snap_d;
         pending_q <= pending_d;
         changed_q <= accept;
         ptr_q     <= ptr_d;
         valid_q   <= valid_d;
         chan_q    <= chan_d;
         value_q   <= value_d;
         ovf_q     <= ovf_d;
      end
   end

   assign o_changed  = changed_q;
   assign o_valid    = valid_q;
   assign o_chan     = chan_q;
   assign o_value    = value_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_diff_multi.sv
// Directed bench for diff_multi (CHANNELS=4, DATA_WIDTH=8); debounce scenarios run when DIFF_DEBOUNCE_EN is defined.
module tb_diff_multi;

   logic        clk, rst, en, ready, clr_ovf;
   logic [31:0] data;
   logic [3:0]  mask;
   logic [3:0]  changed;
   logic        valid, ovf;
   logic [1:0]  chan;
   logic [7:0]  value;
   int          errors = 0;
   int          checks = 0;

   diff_multi #(.DATA_WIDTH(8), .CHANNELS(4), .STABLE_COUNT(3)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_mask(mask),
      .i_ready(ready), .i_clr_ovf(clr_ovf), .o_changed(changed), .o_valid(valid),
      .o_chan(chan), .o_value(value), .o_overflow(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b1; data = '0; mask = '0; ready = 1'b1; clr_ovf = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      en = 1'b1; data = 32'hDEAD_BEEF; mask = '0; ready = 1'b0; clr_ovf = 1'b0;
      rst = 1'b1;
      #2;
      checks++; if ({changed, valid, chan, value, ovf} !== 16'h0) begin errors++;
         $display("FAIL reset_outputs got=%h exp=0000", {changed, valid, chan, value, ovf}); end
      tick();
      checks++; if ({changed, valid, chan, value, ovf} !== 16'h0) begin errors++;
         $display("FAIL reset_held got=%h exp=0000", {changed, valid, chan, value, ovf}); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      tick(); tick();
      data[23:16] = 8'hA5;
      tick();
      checks++; if ({changed, valid} !== 5'b0100_0) begin errors++;
         $display("FAIL single_pulse got=%b exp=01000", {changed, valid}); end
      tick();
      checks++; if ({changed, valid, chan, value} !== {4'b0000, 1'b1, 2'd2, 8'hA5}) begin errors++;
         $display("FAIL single_event got=%h exp=%h", {changed, valid, chan, value}, {4'b0000, 1'b1, 2'd2, 8'hA5}); end
      tick();
      checks++; if (valid !== 1'b0) begin errors++;
         $display("FAIL single_drain got=%b exp=0", valid); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_ch [3];
      logic [7:0] exp_v  [3];
      exp_ch = '{2'd0, 2'd1, 2'd3};
      exp_v  = '{8'h33, 8'h22, 8'h11};
      do_reset();
      data = {8'h11, 8'h00, 8'h22, 8'h33};
      tick();
      checks++; if ({changed, valid} !== 5'b1011_0) begin errors++;
         $display("FAIL b2b_pulse got=%b exp=10110", {changed, valid}); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if ({valid, chan, value} !== {1'b1, exp_ch[k], exp_v[k]}) begin errors++;
            $display("FAIL b2b_event%0d got=%h exp=%h", k, {valid, chan, value}, {1'b1, exp_ch[k], exp_v[k]}); end
      end
      tick();
      checks++; if (valid !== 1'b0) begin errors++;
         $display("FAIL b2b_idle got=%b exp=0", valid); end
      // Pointer back at 0: ch2 must be served before ch3.
      data = {8'h55, 8'h44, 8'h22, 8'h33};
      tick();
      tick();
      checks++; if ({valid, chan, value} !== {1'b1, 2'd2, 8'h44}) begin errors++;
         $display("FAIL b2b_ptr_first got=%h exp=%h", {valid, chan, value}, {1'b1, 2'd2, 8'h44}); end
      tick();
      checks++; if ({valid, chan, value} !== {1'b1, 2'd3, 8'h55}) begin errors++;
         $display("FAIL b2b_ptr_second got=%h exp=%h", {valid, chan, value}, {1'b1, 2'd3, 8'h55}); end
   endtask

   task automatic test_overflow();
      do_reset();
      ready = 1'b0;
      data[15:8] = 8'h10;
      tick();
      checks++; if ({changed, valid, ovf} !== 6'b0010_0_0) begin errors++;
         $display("FAIL ovf_first got=%b exp=001000", {changed, valid, ovf}); end
      data[15:8] = 8'h20;
      tick();
      checks++; if ({valid, chan, value, ovf} !== {1'b1, 2'd1, 8'h10, 1'b0}) begin errors++;
         $display("FAIL ovf_load_set got=%h exp=%h", {valid, chan, value, ovf}, {1'b1, 2'd1, 8'h10, 1'b0}); end
      data[15:8] = 8'h30;
      tick();
      checks++; if ({valid, chan, value, ovf} !== {1'b1, 2'd1, 8'h10, 1'b1}) begin errors++;
         $display("FAIL ovf_raised got=%h exp=%h", {valid, chan, value, ovf}, {1'b1, 2'd1, 8'h10, 1'b1}); end
      tick();
      checks++; if ({valid, chan, value, changed} !== {1'b1, 2'd1, 8'h10, 4'b0000}) begin errors++;
         $display("FAIL ovf_hold got=%h exp=%h", {valid, chan, value, changed}, {1'b1, 2'd1, 8'h10, 4'b0000}); end
      ready = 1'b1;
      tick();
      checks++; if ({valid, chan, value} !== {1'b1, 2'd1, 8'h30}) begin errors++;
         $display("FAIL ovf_newest got=%h exp=%h", {valid, chan, value}, {1'b1, 2'd1, 8'h30}); end
      tick();
      checks++; if ({valid, ovf} !== 2'b01) begin errors++;
         $display("FAIL ovf_sticky got=%b exp=01", {valid, ovf}); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++; if (ovf !== 1'b0) begin errors++;
         $display("FAIL ovf_clear got=%b exp=0", ovf); end
   endtask

   task automatic test_mask();
      do_reset();
      mask = 4'b0001;
      data[7:0] = 8'h55;
      tick();
      checks++; if ({changed, valid} !== 5'b0001_0) begin errors++;
         $display("FAIL mask_pulse got=%b exp=00010", {changed, valid}); end
      tick();
      checks++; if ({changed, valid} !== 5'b0000_0) begin errors++;
         $display("FAIL mask_no_event got=%b exp=00000", {changed, valid}); end
      tick();
      checks++; if ({changed, valid, ovf} !== 6'b0) begin errors++;
         $display("FAIL mask_quiet got=%b exp=000000", {changed, valid, ovf}); end
   endtask

   task automatic test_enable_reset();
      do_reset();
      en = 1'b0;
      data[31:24] = 8'h7F;
      tick(); tick();
      checks++; if ({changed, valid} !== 5'b0) begin errors++;
         $display("FAIL en_off got=%b exp=00000", {changed, valid}); end
      en = 1'b1;
      tick();
      checks++; if ({changed, valid} !== 5'b1000_0) begin errors++;
         $display("FAIL en_pulse got=%b exp=10000", {changed, valid}); end
      ready = 1'b0;
      tick();
      checks++; if ({valid, chan, value} !== {1'b1, 2'd3, 8'h7F}) begin errors++;
         $display("FAIL en_event got=%h exp=%h", {valid, chan, value}, {1'b1, 2'd3, 8'h7F}); end
      rst = 1'b1;
      #1;
      checks++; if ({valid, chan, value, changed, ovf} !== 16'h0) begin errors++;
         $display("FAIL rst_async got=%h exp=0000", {valid, chan, value, changed, ovf}); end
      data = '0;
      @(negedge clk); rst = 1'b0;
      ready = 1'b1;
      tick(); tick(); tick();
      checks++; if ({valid, changed} !== 5'b0) begin errors++;
         $display("FAIL rst_no_resume got=%b exp=00000", {valid, changed}); end
   endtask

   task automatic test_debounce();
      logic [7:0] seq [5];
      seq = '{8'h00, 8'h11, 8'h22, 8'h22, 8'h22};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         data[7:0] = seq[k];
         tick();
         checks++; if ({changed, valid} !== 5'b0) begin errors++;
            $display("FAIL deb_wait%0d got=%b exp=00000", k, {changed, valid}); end
      end
      data[7:0] = seq[4];
      tick();
      checks++; if (changed !== 4'b0001) begin errors++;
         $display("FAIL deb_accept got=%b exp=0001", changed); end
      tick();
      checks++; if ({valid, chan, value} !== {1'b1, 2'd0, 8'h22}) begin errors++;
         $display("FAIL deb_event got=%h exp=%h", {valid, chan, value}, {1'b1, 2'd0, 8'h22}); end
      do_reset();
      data[7:0] = 8'h11;
      tick();
      data[7:0] = 8'h00;
      tick(); tick(); tick(); tick();
      checks++; if ({changed, valid} !== 5'b0) begin errors++;
         $display("FAIL deb_glitch got=%b exp=00000", {changed, valid}); end
   endtask

   initial begin
      rst = 1'b0;
      test_reset();
`ifdef DIFF_DEBOUNCE_EN
      test_debounce();
`else
      test_single();
      test_back_to_back();
      test_overflow();
      test_mask();
      test_enable_reset();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
